// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock through one full-subtractor cell.
// Latency WIDTH clocks from acceptance to out_valid; holds the result in DONE until out_ready, no same-cycle re-accept.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, result, result_nxt, d_vec;
  logic [CW-1:0]    count;
  logic             borrow, borrow_nxt, d, a_msb, b_msb, accept, last_bit;

  // One full-subtractor cell; new bit enters the result register at the MSB end.
  always_comb begin
    d          = sh_a[0] ^ sh_b[0] ^ borrow;
    borrow_nxt = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow);
    d_vec      = '0;
    d_vec[WIDTH-1] = d;
    result_nxt = (result >> 1) | d_vec;
    last_bit   = (count == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      result   <= '0;
      count    <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sh_a   <= a;
      sh_b   <= b;
      borrow <= bin;
      count  <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      result <= result_nxt;
      borrow <= borrow_nxt;
      if (last_bit) begin
        // On the final edge d is the result MSB, so signed overflow is decided here.
        diff     <= result_nxt;
        bout     <= borrow_nxt;
        overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=1: directed table, latency, backpressure, reset, random scoreboard.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, iv8, ir8, ov8, or8, bin8, bout8, ovf8;
  logic [7:0] a8, b8, d8;
  logic       rst1, iv1, ir1, ov1, or1, bin1, bout1, ovf1;
  logic [0:0] a1, b1, d1;
  logic       done8, done1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bout8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bin1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bout1), .overflow(ovf1)
  );

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] diff;
    logic       bout, ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout, ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - 9'(bin);
    e.diff = r[7:0];
    e.bout = r[8];
    e.ovf  = (a[7] != b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  function automatic exp_t model1(input logic a, input logic b, input logic bin);
    logic [1:0] r;
    exp_t e;
    r = {1'b0, a} - {1'b0, b} - 2'(bin);
    e.diff = {7'b0, r[0]};
    e.bout = r[1];
    e.ovf  = (a != b) && (r[0] != a);
    return e;
  endfunction

  // Results are compared on the cycle their handshake completes.
  always @(negedge clk) begin
    if (!rst8 && ov8 && or8) begin
      exp_t e;
      if (q8.size() == 0) check("w8_unexpected_result", 32'(d8), 32'hDEAD);
      else begin
        e = q8.pop_front();
        check("w8_result", {d8, bout8, ovf8}, {e.diff, e.bout, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && ov1 && or1) begin
      exp_t e;
      if (q1.size() == 0) check("w1_unexpected_result", 32'(d1), 32'hDEAD);
      else begin
        e = q1.pop_front();
        check("w1_result", {d1, bout1, ovf1}, {e.diff[0], e.bout, e.ovf});
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 just after the acceptance edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e);
    int n;
    n = 0;
    iv8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    while (!ir8 && n < 200) begin @(posedge clk); #2; n++; end
    if (n >= 200) begin
      check("w8_accept_timeout", 32'(n), 32'd0);
      iv8 = 1'b0;
      return;
    end
    q8.push_back(e);
    @(posedge clk); #2;
    iv8 = 1'b0;
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 300) begin @(posedge clk); #2; n++; end
    if (q8.size() != 0) begin
      check("w8_drain_timeout", 32'(q8.size()), 32'd0);
      q8.delete();
    end
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 300) begin @(posedge clk); #2; n++; end
    if (q1.size() != 0) begin
      check("w1_drain_timeout", 32'(q1.size()), 32'd0);
      q1.delete();
    end
  endtask

  task automatic rand8(input int nops);
    done8 = 1'b0;
    fork
      begin
        for (int k = 0; k < nops; k++) begin
          int n;
          n = 0;
          iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
          while (!ir8 && n < 100) begin @(posedge clk); #2; n++; end
          if (n >= 100) begin check("w8_rand_accept_timeout", 32'(n), 32'd0); break; end
          q8.push_back(model8(a8, b8, bin8));
          @(posedge clk); #2;
        end
        iv8 = 1'b0;
        done8 = 1'b1;
      end
      begin
        while (!done8) begin @(posedge clk); #2; or8 = 1'($urandom); end
      end
    join
    or8 = 1'b1;
    drain8();
  endtask

  task automatic rand1(input int nops);
    done1 = 1'b0;
    fork
      begin
        for (int k = 0; k < nops; k++) begin
          int n;
          n = 0;
          iv1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
          while (!ir1 && n < 100) begin @(posedge clk); #2; n++; end
          if (n >= 100) begin check("w1_rand_accept_timeout", 32'(n), 32'd0); break; end
          q1.push_back(model1(a1[0], b1[0], bin1));
          @(posedge clk); #2;
        end
        iv1 = 1'b0;
        done1 = 1'b1;
      end
      begin
        while (!done1) begin @(posedge clk); #2; or1 = 1'($urandom); end
      end
    join
    or1 = 1'b1;
    drain1();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    exp_t e;
    int   lat, n;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    done8 = 1'b0; done1 = 1'b0;

    #2;
    check("rst_in_ready", 32'(ir8), 32'd0);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_diff_bout_ovf", {d8, bout8, ovf8}, 32'd0);
    check("rst_w1_in_ready", 32'(ir1), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst8 = 1'b0; rst1 = 1'b0;
    #1;
    check("idle_in_ready", 32'(ir8), 32'd1);
    @(posedge clk); #2;

    // First table entry also measures acceptance-to-valid latency.
    e = '{tbl[0].diff, tbl[0].bout, tbl[0].ovf};
    send8(tbl[0].a, tbl[0].b, tbl[0].bin, e);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ov8) break;
    end
    check("w8_latency", 32'(lat), 32'd8);
    @(posedge clk); #2;
    or8 = 1'b1;
    drain8();

    for (int i = 1; i < 7; i++) begin
      e = '{tbl[i].diff, tbl[i].bout, tbl[i].ovf};
      send8(tbl[i].a, tbl[i].b, tbl[i].bin, e);
      drain8();
    end

    // Backpressure in DONE with a competing request held on the input.
    or8 = 1'b0;
    send8(8'h33, 8'h11, 1'b0, '{8'h22, 1'b0, 1'b0});
    n = 0;
    while (!ov8 && n < 50) begin @(posedge clk); #2; n++; end
    check("bp_reach_done", 32'(ov8), 32'd1);
    iv8 = 1'b1; a8 = 8'h44; b8 = 8'h04; bin8 = 1'b0;
    q8.push_back('{8'h40, 1'b0, 1'b0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(ov8), 32'd1);
      check("bp_in_ready", 32'(ir8), 32'd0);
      check("bp_diff_stable", 32'(d8), 32'h22);
      @(posedge clk); #2;
    end
    or8 = 1'b1;
    @(posedge clk); #2;
    check("bp_release_in_ready", 32'(ir8), 32'd1);
    check("bp_release_out_valid", 32'(ov8), 32'd0);
    @(posedge clk); #2;
    iv8 = 1'b0;
    check("bp_new_op_accepted", 32'(ir8), 32'd0);
    drain8();

    // Reset after four bit edges discards the operation.
    send8(8'h55, 8'h22, 1'b0, '{8'h33, 1'b0, 1'b0});
    repeat (4) @(posedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    check("midrst_out_valid", 32'(ov8), 32'd0);
    check("midrst_in_ready", 32'(ir8), 32'd0);
    q8.delete();
    @(posedge clk); @(posedge clk); #2;
    rst8 = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", 32'(ov8), 32'd0);
    check("postrst_in_ready", 32'(ir8), 32'd1);
    @(posedge clk); #2;
    send8(8'h0A, 8'h04, 1'b0, '{8'h06, 1'b0, 1'b0});
    drain8();

    rand8(1000);
    rand1(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
